// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Measures the high and low phase widths (in clk cycles) of an asynchronous
//   1-bit signal, typically the output of a delayed-inverter net stage.
//   Each completed phase is reported once through a valid/ready output with a
//   one-entry holding register; a measurement that cannot be accepted is
//   dropped and flagged in the sticky ovf bit.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - measurement enable (0 forces the FSM back to IDLE)
//   sig_in     - asynchronous signal under measurement
//   meas_ready - consumer accepts the current measurement
//   clr_ovf    - synchronous clear of ovf
//   meas_valid - measurement available
//   meas_width - phase length in clk cycles (saturating)
//   meas_level - level of the measured phase (1 = high, 0 = low)
//   ovf        - sticky: a measurement was dropped
module pulse_width_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             meas_ready,
  input  logic             clr_ovf,
  output logic             meas_valid,
  output logic [WIDTH-1:0] meas_width,
  output logic             meas_level,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Synchronizer: the only logic that samples sig_in.
  logic [SYNC_STAGES-1:0] sync;
  logic                   sig_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], sig_in};
  end

  assign sig_s = sync[SYNC_STAGES-1];

  // Phase FSM
  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  // armed/ref_lvl hold the level seen on the first enabled IDLE cycle so the
  // partial phase in progress at enable time is never reported.
  logic             armed, armed_nxt;
  logic             ref_lvl, ref_nxt;
  logic             emit, emit_level;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      armed   <= 1'b0;
      ref_lvl <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      armed   <= armed_nxt;
      ref_lvl <= ref_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    armed_nxt  = armed;
    ref_nxt    = ref_lvl;
    emit       = 1'b0;
    emit_level = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      armed_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!armed) begin
            armed_nxt = 1'b1;
            ref_nxt   = sig_s;
          end else if (sig_s != ref_lvl) begin
            state_nxt = sig_s ? HIGH : LOW;
            cnt_nxt   = CNT_ONE;
            armed_nxt = 1'b0;
          end
        end
        HIGH: begin
          if (sig_s) begin
            cnt_nxt = cnt_inc;
          end else begin
            emit       = 1'b1;
            emit_level = 1'b1;
            state_nxt  = LOW;
            cnt_nxt    = CNT_ONE;
          end
        end
        LOW: begin
          if (!sig_s) begin
            cnt_nxt = cnt_inc;
          end else begin
            emit       = 1'b1;
            emit_level = 1'b0;
            state_nxt  = HIGH;
            cnt_nxt    = CNT_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output holding register. A new emit can load whenever the slot is empty
  // or is being drained on this same edge (no bubble back-to-back).
  logic xfer, load, drop;

  assign xfer = meas_valid & meas_ready;
  assign load = emit & (~meas_valid | meas_ready);
  assign drop = emit & meas_valid & ~meas_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid <= 1'b0;
      meas_width <= '0;
      meas_level <= 1'b0;
    end else if (load) begin
      meas_valid <= 1'b1;
      meas_width <= cnt;
      meas_level <= emit_level;
    end else if (xfer) begin
      meas_valid <= 1'b0;
    end
  end

  // Set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter (WIDTH=4 to reach saturation).
// Stimulus pushes expected {level,width} before driving each full phase; the
// monitor pops and compares on every output transfer.
module tb_pulse_width_meter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic         meas_ready = 1'b1;
  logic         clr_ovf = 1'b0;
  logic         meas_valid;
  logic [W-1:0] meas_width;
  logic         meas_level;
  logic         ovf;

  int passed = 0;
  int total  = 0;
  logic [W:0] q[$];
  logic [W:0] exp_e;

  pulse_width_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .meas_ready(meas_ready), .clr_ovf(clr_ovf),
    .meas_valid(meas_valid), .meas_width(meas_width),
    .meas_level(meas_level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic expect_meas(input logic lvl, input int w);
    q.push_back({lvl, W'(w)});
  endtask

  // Drive sig_in for n sampling edges; returns at posedge+1.
  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && meas_valid && meas_ready) begin
      total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_meas: got level=%0d width=%0d, none expected",
                 meas_level, meas_width);
      end else begin
        exp_e = q.pop_front();
        if ({meas_level, meas_width} === exp_e) passed++;
        else $display("FAIL meas: got level=%0d width=%0d expected level=%0d width=%0d",
                      meas_level, meas_width, exp_e[W], exp_e[W-1:0]);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", meas_valid, 0);
    chk("rst_width", meas_width, 0);
    chk("rst_level", meas_level, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;

    // Basic: partial low discarded, then {1,5},{0,3} alternating
    drive(0, 10);
    for (int i = 0; i < 3; i++) begin
      expect_meas(1, 5);
      drive(1, 5);
      expect_meas(0, 3);
      sig_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (i == 0) chk("latency_valid", meas_valid, (k == 2) ? 1 : 0);
      end
    end
    drive(1, 4);
    chk("single_cycle_valid", meas_valid, 0);
    en = 1'b0;
    drive(1, 3);

    // Saturation
    drive(0, 4);
    en = 1'b1;
    drive(0, 3);
    expect_meas(1, 15);
    drive(1, 20);
    expect_meas(0, 3);
    drive(0, 3);
    drive(1, 4);
    en = 1'b0;
    drive(1, 4);

    // Backpressure: {0,4} held, {1,6} dropped
    meas_ready = 1'b0;
    en = 1'b1;
    drive(1, 3);
    drive(0, 4);
    drive(1, 6);
    chk("bp_valid", meas_valid, 1);
    chk("bp_width_held", meas_width, 4);
    chk("bp_level_held", meas_level, 0);
    chk("bp_ovf_clear", ovf, 0);
    drive(0, 3);
    chk("bp_width_kept", meas_width, 4);
    chk("bp_level_kept", meas_level, 0);
    chk("bp_ovf_set", ovf, 1);
    en = 1'b0;
    expect_meas(0, 4);
    meas_ready = 1'b1;
    @(posedge clk); #1;
    meas_ready = 1'b0;
    chk("bp_drained", meas_valid, 0);
    chk("bp_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 0);

    // Back-to-back 1-cycle phases
    meas_ready = 1'b1;
    drive(0, 3);
    en = 1'b1;
    drive(0, 3);
    for (int i = 0; i < 8; i++) begin
      expect_meas(1, 1);
      drive(1, 1);
      expect_meas(0, 1);
      drive(0, 1);
      if (i >= 2) begin
        chk("b2b_valid", meas_valid, 1);
        chk("b2b_ovf", ovf, 0);
      end
    end
    drive(1, 4);
    en = 1'b0;
    drive(1, 2);

    // Reset mid-phase with a pending measurement
    meas_ready = 1'b0;
    en = 1'b1;
    drive(1, 3);
    drive(0, 4);
    drive(1, 7);
    chk("pre_rst_valid", meas_valid, 1);
    rst = 1'b1;
    sig_in = 1'b0;
    #1;
    chk("async_rst_valid", meas_valid, 0);
    chk("async_rst_width", meas_width, 0);
    chk("async_rst_level", meas_level, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    meas_ready = 1'b1;
    drive(0, 3);
    expect_meas(1, 6);
    drive(1, 6);
    expect_meas(0, 2);
    drive(0, 2);
    drive(1, 4);
    en = 1'b0;
    drive(1, 2);

    // Enable drop with a pending measurement
    meas_ready = 1'b0;
    en = 1'b1;
    drive(1, 3);
    drive(0, 5);
    drive(1, 4);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("en_pending_valid", meas_valid, 1);
      chk("en_pending_width", meas_width, 5);
    end
    en = 1'b1;
    drive(1, 3);
    expect_meas(0, 5);
    meas_ready = 1'b1;
    expect_meas(0, 4);
    drive(0, 4);
    drive(1, 3);
    en = 1'b0;
    drive(1, 4);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
